// File: rtl/mem_addr_unit.sv
// mem_addr_unit: memory address source for the multicycle datapath.
// In IDLE it is a zero-latency mux over pc_in / alu_in / aux_in.
// On an exception it latches EPC and cause, drives the cause-specific
// vector address for MEM_LATENCY cycles, captures the handler byte from
// memory, and then presents handler_pc together with a one-cycle exc_done.
module mem_addr_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned VEC_BASE    = 253,
  parameter int unsigned PC_ADJUST   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       addr_sel,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] alu_in,
  input  logic [WIDTH-1:0] aux_in,
  input  logic             exc_req,
  input  logic [1:0]       exc_cause,
  input  logic [WIDTH-1:0] pc_cur,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] mem_addr,
  output logic             busy,
  output logic             exc_done,
  output logic [WIDTH-1:0] handler_pc,
  output logic [WIDTH-1:0] epc_out,
  output logic [1:0]       cause_out
);

  // Wait counter only ever holds values 0..MEM_LATENCY.
  localparam int unsigned CNT_W = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_VEC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic [WIDTH-1:0] handler_q, handler_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [1:0]       cause_q, cause_d;

  logic [1:0]       cause_map;
  logic [WIDTH-1:0] idle_addr;

  // Only the low byte of the memory word carries the handler address.
  logic unused_rdata_hi;
  assign unused_rdata_hi = ^mem_rdata[WIDTH-1:8];

  // The reserved cause code shares the invalid-opcode vector.
  assign cause_map = (exc_cause == 2'd3) ? 2'd0 : exc_cause;

  // Plain address mux used whenever no exception sequence is running.
  always_comb begin
    case (addr_sel)
      2'd0:    idle_addr = pc_in;
      2'd1:    idle_addr = alu_in;
      default: idle_addr = aux_in;
    endcase
  end

  // Next-state and output decode for the vector-fetch sequence.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    vec_d     = vec_q;
    handler_d = handler_q;
    epc_d     = epc_q;
    cause_d   = cause_q;
    mem_addr  = vec_q;
    busy      = 1'b1;
    exc_done  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy     = 1'b0;
        mem_addr = idle_addr;
        if (exc_req) begin
          state_d = ST_VEC;
          cnt_d   = CNT_W'(MEM_LATENCY);
          vec_d   = WIDTH'(VEC_BASE) + WIDTH'(cause_map);
          epc_d   = pc_cur - WIDTH'(PC_ADJUST);
          cause_d = cause_map;
        end
      end

      ST_VEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Memory data is valid in the last VEC cycle, when the counter reads 1.
        if (cnt_q == CNT_W'(1)) begin
          handler_d = WIDTH'(mem_rdata[7:0]);
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        exc_done = 1'b1;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      // NOTE: every register is cleared, so a sequence aborted by reset leaves nothing stale.
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      vec_q     <= '0;
      handler_q <= '0;
      epc_q     <= '0;
      cause_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vec_q     <= vec_d;
      handler_q <= handler_d;
      epc_q     <= epc_d;
      cause_q   <= cause_d;
    end
  end

  assign handler_pc = handler_q;
  assign epc_out    = epc_q;
  assign cause_out  = cause_q;

endmodule

// File: tb/tb_mem_addr_unit.sv
// tb_mem_addr_unit: drives two instances (MEM_LATENCY 1 and 3) with shared
// stimulus and compares every cycle against a sequence-position reference
// model. The memory model only returns correct data once an address has
// been held for MEM_LATENCY cycles, so early capture shows up as bad data.
module tb_mem_addr_unit;

  localparam int W        = 32;
  localparam int LAT_A    = 1;
  localparam int LAT_B    = 3;
  localparam int VBASE    = 253;
  localparam int PADJ     = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         exc_req;
  logic [1:0]   addr_sel;
  logic [1:0]   exc_cause;
  logic [W-1:0] pc_in, alu_in, aux_in, pc_cur;

  logic [W-1:0] rdata_a, rdata_b, addr_a, addr_b;
  logic [W-1:0] handler_a, handler_b, epc_a, epc_b;
  logic         busy_a, busy_b, done_a, done_b;
  logic [1:0]   cause_a, cause_b;

  int n_cmp = 0;
  int n_bad = 0;

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  mem_addr_unit #(.WIDTH(W), .MEM_LATENCY(LAT_A), .VEC_BASE(VBASE), .PC_ADJUST(PADJ)) dut_a (
    .clk(clk), .reset(reset), .addr_sel(addr_sel), .pc_in(pc_in), .alu_in(alu_in),
    .aux_in(aux_in), .exc_req(exc_req), .exc_cause(exc_cause), .pc_cur(pc_cur),
    .mem_rdata(rdata_a), .mem_addr(addr_a), .busy(busy_a), .exc_done(done_a),
    .handler_pc(handler_a), .epc_out(epc_a), .cause_out(cause_a)
  );

  mem_addr_unit #(.WIDTH(W), .MEM_LATENCY(LAT_B), .VEC_BASE(VBASE), .PC_ADJUST(PADJ)) dut_b (
    .clk(clk), .reset(reset), .addr_sel(addr_sel), .pc_in(pc_in), .alu_in(alu_in),
    .aux_in(aux_in), .exc_req(exc_req), .exc_cause(exc_cause), .pc_cur(pc_cur),
    .mem_rdata(rdata_b), .mem_addr(addr_b), .busy(busy_b), .exc_done(done_b),
    .handler_pc(handler_b), .epc_out(epc_b), .cause_out(cause_b)
  );

  // ---------------- memory model ----------------
  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    if (a == 32'd254) return 32'h0000_0A7C;
    return (a * 32'h9E37_79B1) ^ 32'h00C3_5A00;
  endfunction

  logic [W-1:0] prev_addr_a = '1;
  logic [W-1:0] prev_addr_b = '1;
  int           prev_run_a  = 0;
  int           prev_run_b  = 0;
  int           run_a, run_b;

  // Data is correct only after the address has been stable for the latency.
  always_comb begin
    run_a   = (addr_a == prev_addr_a) ? prev_run_a + 1 : 1;
    run_b   = (addr_b == prev_addr_b) ? prev_run_b + 1 : 1;
    rdata_a = (run_a >= LAT_A) ? mem_word(addr_a) : (mem_word(addr_a) ^ 32'h0000_00A5);
    rdata_b = (run_b >= LAT_B) ? mem_word(addr_b) : (mem_word(addr_b) ^ 32'h0000_00A5);
  end

  // Track how long each memory address has been held.
  always @(posedge clk) begin
    prev_addr_a <= addr_a;
    prev_addr_b <= addr_b;
    prev_run_a  <= run_a;
    prev_run_b  <= run_b;
  end

  // ---------------- reference model ----------------
  // m_pos: 0 = no sequence, 1..lat = cycle within the vector wait, lat+1 = done cycle.
  int           lat [2] = '{LAT_A, LAT_B};
  int           m_pos [2];
  logic [W-1:0] m_vec [2];
  logic [W-1:0] m_hand [2];
  logic [W-1:0] m_epc [2];
  logic [1:0]   m_cause [2];
  int           m_done_cnt [2];
  int           o_done_cnt [2];

  function automatic logic [W-1:0] mux_ref(input logic [1:0] s);
    if (s == 2'd0) return pc_in;
    if (s == 2'd1) return alu_in;
    return aux_in;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      m_pos[d]   = 0;
      m_vec[d]   = '0;
      m_hand[d]  = '0;
      m_epc[d]   = '0;
      m_cause[d] = '0;
    end
  endtask

  task automatic model_edge();
    logic [1:0] c;
    if (reset) begin
      model_clear();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      if (m_pos[d] == 0) begin
        if (exc_req) begin
          c          = (exc_cause == 2'd3) ? 2'd0 : exc_cause;
          m_vec[d]   = VBASE + c;
          m_epc[d]   = pc_cur - PADJ;
          m_cause[d] = c;
          m_pos[d]   = 1;
        end
      end else if (m_pos[d] == lat[d] + 1) begin
        m_pos[d] = 0;
      end else begin
        if (m_pos[d] == lat[d]) m_hand[d] = mem_word(m_vec[d]) & 32'h0000_00FF;
        m_pos[d] = m_pos[d] + 1;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input int d, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s[%0d]: observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [W-1:0] exp_addr;
    for (int d = 0; d < 2; d++) begin
      exp_addr = (m_pos[d] != 0) ? m_vec[d] : mux_ref(addr_sel);
      if (m_pos[d] == lat[d] + 1) m_done_cnt[d]++;
      check("mem_addr",   d, (d == 0) ? addr_a    : addr_b,         exp_addr);
      check("busy",       d, W'((d == 0) ? busy_a : busy_b),        W'(m_pos[d] != 0));
      check("exc_done",   d, W'((d == 0) ? done_a : done_b),        W'(m_pos[d] == lat[d] + 1));
      check("handler_pc", d, (d == 0) ? handler_a : handler_b,      m_hand[d]);
      check("epc_out",    d, (d == 0) ? epc_a     : epc_b,          m_epc[d]);
      check("cause_out",  d, W'((d == 0) ? cause_a : cause_b),      W'(m_cause[d]));
      if (((d == 0) ? done_a : done_b) === 1'b1) o_done_cnt[d]++;
    end
  endtask

  // One cycle: apply inputs after the falling edge, compare, then clock.
  task automatic step(input logic rst, input logic req, input logic [1:0] cause,
                      input logic [1:0] sel, input logic [W-1:0] pcc);
    reset     = rst;
    exc_req   = req;
    exc_cause = cause;
    addr_sel  = sel;
    pc_cur    = pcc;
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 2'd0, '0);
  endtask

  logic [W-1:0] mux_lit [4] = '{32'h100, 32'h200, 32'h300, 32'h300};

  // Directed scenarios followed by randomized traffic.
  initial begin
    reset = 1'b1; exc_req = 1'b0; exc_cause = 2'd0; addr_sel = 2'd0; pc_cur = '0;
    pc_in = 32'h100; alu_in = 32'h200; aux_in = 32'h300;
    model_clear();
    for (int d = 0; d < 2; d++) begin
      m_done_cnt[d] = 0;
      o_done_cnt[d] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state.
    step(1'b1, 1'b0, 2'd0, 2'd0, '0);
    check("rst_handler", 0, handler_a, 32'h0);
    check("rst_epc",     1, epc_b,     32'h0);
    check("rst_busy",    0, W'(busy_a), 32'h0);

    // Normal mux, all four selects.
    for (int s = 0; s < 4; s++) begin
      step(1'b0, 1'b0, 2'd0, s[1:0], '0);
      check("mux_lit", 0, addr_a, mux_lit[s]);
    end

    // Overflow exception on the latency-1 instance.
    step(1'b0, 1'b1, 2'd1, 2'd1, 32'h40);
    check("ovf_vec_addr", 0, addr_a,       32'd254);
    check("ovf_epc",      0, epc_a,        32'h3C);
    check("ovf_cause",    0, W'(cause_a),  32'd1);
    check("ovf_no_done",  0, W'(done_a),   32'd0);
    step(1'b0, 1'b0, 2'd0, 2'd2, '0);
    check("ovf_done",     0, W'(done_a),   32'd1);
    check("ovf_handler",  0, handler_a,    32'h7C);
    check("ovf_done_addr",0, addr_a,       32'd254);
    idle(4);

    // Reserved cause on the latency-3 instance.
    step(1'b0, 1'b1, 2'd3, 2'd0, 32'h1000);
    for (int k = 1; k <= 4; k++) begin
      check("rsv_addr", 1, addr_b,      32'd253);
      check("rsv_done", 1, W'(done_b),  W'(k == 4));
      check("rsv_cause",1, W'(cause_b), 32'd0);
      step(1'b0, 1'b0, 2'd0, 2'd1, '0);
    end
    check("rsv_idle", 1, W'(busy_b), 32'd0);
    idle(2);

    // exc_req held high: re-acceptance only after each sequence completes.
    for (int i = 0; i < 14; i++)
      step(1'b0, 1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom);
    idle(5);

    // Reset while in VEC aborts the sequence without a done pulse.
    step(1'b0, 1'b1, 2'd2, 2'd0, 32'h80);
    step(1'b1, 1'b0, 2'd0, 2'd0, '0);
    check("rv_busy",    1, W'(busy_b), 32'd0);
    check("rv_handler", 0, handler_a,  32'h0);
    check("rv_epc",     1, epc_b,      32'h0);
    idle(2);
    step(1'b0, 1'b1, 2'd2, 2'd0, 32'h90);
    idle(5);
    check("rv_after_handler", 1, handler_b, mem_word(32'd255) & 32'hFF);
    check("rv_after_epc",     1, epc_b,     32'h8C);

    // EPC wrap-around.
    step(1'b0, 1'b1, 2'd0, 2'd0, 32'h2);
    check("wrap_epc", 0, epc_a, 32'hFFFF_FFFE);
    check("wrap_epc", 1, epc_b, 32'hFFFF_FFFE);
    idle(5);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      pc_in  = $urandom;
      alu_in = $urandom;
      aux_in = $urandom;
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom);
    end
    idle(6);

    for (int d = 0; d < 2; d++) check("done_count", d, W'(o_done_cnt[d]), W'(m_done_cnt[d]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
